// File: rtl/aquila_ctrl_pkg.sv
// Shared types and constants for the Aquila pipeline control block.
package aquila_ctrl_pkg;

  localparam int RA_W_DEF = 5;
  // Scoreboard entries store rd at a fixed width; RA_W must not exceed this.
  localparam int RA_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
  } sb_entry_t;

  localparam logic REDIR_BRANCH = 1'b0;
  localparam logic REDIR_SYS    = 1'b1;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight load scoreboard: LOAD_LAT-deep shift chain of {valid, rd} with
// combinational match against the Decode source registers.
module hazard_scoreboard
  import aquila_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int RA_W     = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            push_vld,
  input  logic [RA_W-1:0] push_rd,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic            hz
);

  sb_entry_t chain [LOAD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LOAD_LAT; k++) chain[k] <= '0;
    end else if (!hold) begin
      chain[0].valid <= push_vld;
      chain[0].rd    <= RA_MAX_W'(push_rd);
      for (int k = 1; k < LOAD_LAT; k++) chain[k] <= chain[k-1];
    end
  end

  // x0 is hard-wired zero, so a pending write to it never blocks a reader.
  always_comb begin
    hz = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (chain[k].valid && (chain[k].rd != '0)) begin
        if (rs1_used && (chain[k].rd == RA_MAX_W'(rs1_addr))) hz = 1'b1;
        if (rs2_used && (chain[k].rd == RA_MAX_W'(rs2_addr))) hz = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Aquila pipeline controller: load scoreboard hazards, stall fan-out and flush
// replay across stalls. Optional perf counters under AQUILA_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import aquila_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int RA_W     = RA_W_DEF
`ifdef AQUILA_HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [RA_W-1:0] rs1_addr_i,
  input  logic [RA_W-1:0] rs2_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            illegal_instr_i,
  input  logic            dec_issue_i,
  input  logic            dec_is_load_i,
  input  logic [RA_W-1:0] dec_rd_addr_i,
  input  logic            branch_taken_i,
  input  logic            cond_branch_hit_i,
  input  logic            uncond_branch_hit_i,
  input  logic            cond_branch_mispred_i,
  input  logic            sys_jump_i,
  input  logic            exe_busy_i,
  input  logic            stall_data_fetch_i,
  input  logic            stall_instr_fetch_i,
  output logic            flush2fet_o,
  output logic            flush2dec_o,
  output logic            stall_from_hazard_o,
  output logic            stall_pipeline_o,
  output logic            stall_mem_access_o,
  output logic            redirect_sys_o
`ifdef AQUILA_HAZARD_PERF_EN
  , output logic [PERF_W-1:0] perf_hazard_cnt_o
  , output logic [PERF_W-1:0] perf_flush_cnt_o
  , output logic [PERF_W-1:0] perf_memstall_cnt_o
`endif
);

  logic stall, bf, req, hz, push_vld;
  logic pend, pend_sys;

  assign stall              = stall_instr_fetch_i | stall_data_fetch_i | exe_busy_i;
  assign stall_pipeline_o   = stall;
  assign stall_mem_access_o = stall_instr_fetch_i | exe_busy_i;

  assign bf  = (branch_taken_i & ~cond_branch_hit_i & ~uncond_branch_hit_i)
             | cond_branch_mispred_i;
  assign req = bf | sys_jump_i;

  // A redirect seen during a stall is replayed on the first free cycle.
  assign flush2fet_o    = ~stall & (req | pend);
  assign redirect_sys_o = (flush2fet_o & (sys_jump_i | pend_sys)) ? REDIR_SYS : REDIR_BRANCH;
  assign flush2dec_o    = (~stall & (flush2fet_o | hz)) | illegal_instr_i;

  assign stall_from_hazard_o = hz;
  assign push_vld = dec_issue_i & dec_is_load_i & (dec_rd_addr_i != '0) & ~flush2dec_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend     <= 1'b0;
      pend_sys <= 1'b0;
    end else if (!stall) begin
      pend     <= 1'b0;
      pend_sys <= 1'b0;
    end else if (req) begin
      pend     <= 1'b1;
      pend_sys <= pend_sys | sys_jump_i;
    end
  end

  hazard_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .RA_W     (RA_W)
  ) u_sb (
    .clk      (clk_i),
    .rst      (rst_i),
    .hold     (stall),
    .push_vld (push_vld),
    .push_rd  (dec_rd_addr_i),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rs1_used (rs1_used_i),
    .rs2_used (rs2_used_i),
    .hz       (hz)
  );

`ifdef AQUILA_HAZARD_PERF_EN
  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hazard_cnt_o   <= '0;
      perf_flush_cnt_o    <= '0;
      perf_memstall_cnt_o <= '0;
    end else begin
      if (hz && (perf_hazard_cnt_o != '1))
        perf_hazard_cnt_o <= perf_hazard_cnt_o + 1'b1;
      if (flush2fet_o && (perf_flush_cnt_o != '1))
        perf_flush_cnt_o <= perf_flush_cnt_o + 1'b1;
      if (stall && (perf_memstall_cnt_o != '1))
        perf_memstall_cnt_o <= perf_memstall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// against a queue-based model of in-flight loads and pending redirects.
module tb_pipeline_hazard_ctrl;

  localparam int LL  = 2;
  localparam int RAW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [RAW-1:0] rs1_addr, rs2_addr, dec_rd_addr;
  logic rs1_used, rs2_used, illegal, dec_issue, dec_is_load;
  logic br_taken, c_hit, u_hit, mispred, sys_jump, exe_busy, dfs, ifs;
  logic f2f, f2d, sfh, sp, sma, rsys;
`ifdef AQUILA_HAZARD_PERF_EN
  logic [31:0] p_hz, p_fl, p_ms;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(LL), .RA_W(RAW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .rs1_addr_i            (rs1_addr),
    .rs2_addr_i            (rs2_addr),
    .rs1_used_i            (rs1_used),
    .rs2_used_i            (rs2_used),
    .illegal_instr_i       (illegal),
    .dec_issue_i           (dec_issue),
    .dec_is_load_i         (dec_is_load),
    .dec_rd_addr_i         (dec_rd_addr),
    .branch_taken_i        (br_taken),
    .cond_branch_hit_i     (c_hit),
    .uncond_branch_hit_i   (u_hit),
    .cond_branch_mispred_i (mispred),
    .sys_jump_i            (sys_jump),
    .exe_busy_i            (exe_busy),
    .stall_data_fetch_i    (dfs),
    .stall_instr_fetch_i   (ifs),
    .flush2fet_o           (f2f),
    .flush2dec_o           (f2d),
    .stall_from_hazard_o   (sfh),
    .stall_pipeline_o      (sp),
    .stall_mem_access_o    (sma),
    .redirect_sys_o        (rsys)
`ifdef AQUILA_HAZARD_PERF_EN
    , .perf_hazard_cnt_o   (p_hz)
    , .perf_flush_cnt_o    (p_fl)
    , .perf_memstall_cnt_o (p_ms)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Model: list of loads still in flight with remaining unstalled cycles of
  // visibility, plus a sticky "redirect owed" flag and its source.
  int q_rd[$];
  int q_left[$];
  bit m_pend, m_psys, m_valid;
  bit e_stall, e_mem, e_hz, e_fet, e_dec, e_rsys, e_req;
  int unsigned c_hz, c_fl, c_ms;

  function automatic void model_eval();
    e_stall = ifs || dfs || exe_busy;
    e_mem   = ifs || exe_busy;
    e_hz    = 0;
    foreach (q_rd[i])
      if (q_rd[i] != 0 && ((rs1_used && q_rd[i] == int'(rs1_addr)) ||
                           (rs2_used && q_rd[i] == int'(rs2_addr))))
        e_hz = 1;
    e_req  = (br_taken && !c_hit && !u_hit) || mispred || sys_jump;
    e_fet  = !e_stall && (e_req || m_pend);
    e_rsys = e_fet && (sys_jump || m_psys);
    e_dec  = (!e_stall && (e_fet || e_hz)) || illegal;
  endfunction

  function automatic void model_update();
    if (rst) begin
      q_rd.delete(); q_left.delete();
      m_pend = 0; m_psys = 0;
      c_hz = 0; c_fl = 0; c_ms = 0;
      return;
    end
    if (e_hz)    c_hz++;
    if (e_fet)   c_fl++;
    if (e_stall) c_ms++;
    if (!e_stall) begin
      for (int i = q_left.size() - 1; i >= 0; i--) begin
        q_left[i]--;
        if (q_left[i] == 0) begin q_left.delete(i); q_rd.delete(i); end
      end
      if (dec_issue && dec_is_load && dec_rd_addr != 0 && !e_dec) begin
        q_rd.push_back(int'(dec_rd_addr));
        q_left.push_back(LL);
      end
      m_pend = 0; m_psys = 0;
    end else if (e_req) begin
      m_pend = 1;
      m_psys = m_psys || sys_jump;
    end
  endfunction

  // Called at a negedge with inputs set; compares, advances one clock.
  task automatic tick();
    #1;
    model_eval();
    if (m_valid) begin
      chk("stall_pipeline", {31'd0, sp}, {31'd0, e_stall});
      chk("stall_mem", {31'd0, sma}, {31'd0, e_mem});
      chk("hazard", {31'd0, sfh}, {31'd0, e_hz});
      chk("flush2fet", {31'd0, f2f}, {31'd0, e_fet});
      chk("flush2dec", {31'd0, f2d}, {31'd0, e_dec});
      chk("redirect_sys", {31'd0, rsys}, {31'd0, e_rsys});
`ifdef AQUILA_HAZARD_PERF_EN
      chk("perf_hz", p_hz, c_hz);
      chk("perf_fl", p_fl, c_fl);
      chk("perf_ms", p_ms, c_ms);
`endif
    end
    @(posedge clk);
    model_update();
    if (rst) m_valid = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_addr = '0; rs2_addr = '0; dec_rd_addr = '0;
    rs1_used = 0; rs2_used = 0; illegal = 0; dec_issue = 0; dec_is_load = 0;
    br_taken = 0; c_hit = 0; u_hit = 0; mispred = 0; sys_jump = 0;
    exe_busy = 0; dfs = 0; ifs = 0;
  endtask

  task automatic issue_load(input int rd);
    idle(); dec_issue = 1; dec_is_load = 1; dec_rd_addr = RAW'(rd);
    tick();
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    #1 chk("rst_f2f", {31'd0, f2f}, 0); chk("rst_f2d", {31'd0, f2d}, 0);
    chk("rst_hz", {31'd0, sfh}, 0); chk("rst_sp", {31'd0, sp}, 0);
    chk("rst_rsys", {31'd0, rsys}, 0);
    tick();

    // load x5 then a dependent add: two bubbles, clear on the third cycle
    issue_load(5);
    idle(); rs1_addr = 5; rs1_used = 1; rs2_addr = 1; rs2_used = 1;
    #1 chk("lu_c1", {31'd0, sfh}, 1); tick();
    #1 chk("lu_c2", {31'd0, sfh}, 1); tick();
    #1 chk("lu_c3", {31'd0, sfh}, 0); tick();
    issue_load(0);
    idle(); rs1_addr = 0; rs1_used = 1;
    #1 chk("lu_x0", {31'd0, sfh}, 0); tick();

    // memory stall freezes the scoreboard
    issue_load(5);
    idle(); rs1_addr = 5; rs1_used = 1; dfs = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ms_hold", {31'd0, sfh}, 1); tick();
    end
    dfs = 0;
    #1 chk("ms_rel1", {31'd0, sfh}, 1); tick();
    #1 chk("ms_rel2", {31'd0, sfh}, 1); tick();
    #1 chk("ms_rel3", {31'd0, sfh}, 0); tick();

    // unpredicted taken branch flushes exactly once
    idle(); br_taken = 1;
    #1 chk("br_f2f", {31'd0, f2f}, 1); chk("br_f2d", {31'd0, f2d}, 1);
    chk("br_src", {31'd0, rsys}, 0);
    tick();
    idle();
    #1 chk("br_once", {31'd0, f2f}, 0); tick();
    idle(); br_taken = 1; c_hit = 1;
    #1 chk("br_pred", {31'd0, f2f}, 0); chk("br_pred_dec", {31'd0, f2d}, 0); tick();

    // mispredict during a 4-cycle busy is replayed once on release
    idle(); exe_busy = 1; mispred = 1;
    #1 chk("busy_nof", {31'd0, f2f}, 0); tick();
    mispred = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("busy_hold", {31'd0, f2f}, 0); tick();
    end
    exe_busy = 0;
    #1 chk("busy_rel", {31'd0, f2f}, 1); chk("busy_src", {31'd0, rsys}, 0); tick();
    #1 chk("busy_once", {31'd0, f2f}, 0); tick();

    // sys_jump and a branch flush in different stalled cycles merge
    idle(); ifs = 1; sys_jump = 1;
    #1 chk("sys_nof", {31'd0, f2f}, 0); tick();
    sys_jump = 0; mispred = 1; tick();
    mispred = 0; tick();
    ifs = 0;
    #1 chk("sys_rel", {31'd0, f2f}, 1); chk("sys_src", {31'd0, rsys}, 1); tick();
    #1 chk("sys_once", {31'd0, f2f}, 0); tick();

    // reset mid-stall drops the pending redirect
    idle(); ifs = 1; mispred = 1; tick();
    mispred = 0; rst = 1; tick();
    rst = 0; ifs = 0;
    #1 chk("rst_drop", {31'd0, f2f}, 0); tick();

`ifdef AQUILA_HAZARD_PERF_EN
    idle(); rst = 1; tick(); rst = 0;
    issue_load(7);
    idle(); rs1_addr = 7; rs1_used = 1; tick(); tick();
    issue_load(7);
    idle(); rs1_addr = 7; rs1_used = 1; tick();
    idle(); br_taken = 1; tick(); tick();
    idle();
    #1 chk("perf_hz_lit", p_hz, 3); chk("perf_fl_lit", p_fl, 2);
    rst = 1; tick(); rst = 0;
    #1 chk("perf_hz_rst", p_hz, 0); chk("perf_fl_rst", p_fl, 0); chk("perf_ms_rst", p_ms, 0);
    tick();
`endif

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      rs1_addr    = RAW'($urandom_range(0, 7));
      rs2_addr    = RAW'($urandom_range(0, 7));
      dec_rd_addr = RAW'($urandom_range(0, 7));
      rs1_used    = 1'($urandom_range(0, 1));
      rs2_used    = 1'($urandom_range(0, 1));
      dec_issue   = 1'($urandom_range(0, 1));
      dec_is_load = 1'($urandom_range(0, 1));
      illegal     = ($urandom_range(0, 19) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      c_hit       = 1'($urandom_range(0, 1));
      u_hit       = ($urandom_range(0, 3) == 0);
      mispred     = ($urandom_range(0, 9) == 0);
      sys_jump    = ($urandom_range(0, 19) == 0);
      exe_busy    = ($urandom_range(0, 5) == 0);
      dfs         = ($urandom_range(0, 5) == 0);
      ifs         = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
